// File: rtl/ins_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// ins_sequencer_pkg
// Shared FSM encoding, INS opcodes and command field widths for the sequencer.
// Revision: 1.0
// ============================================================================
package ins_sequencer_pkg;

  localparam int c_ins_w   = 5;
  localparam int c_f1_w    = 10;
  localparam int c_f2_w    = 10;
  localparam int c_f3_w    = 10;
  localparam int c_cmd_w   = c_ins_w + c_f1_w + c_f2_w + c_f3_w;
  localparam int c_entry_w = c_cmd_w + 1;

  localparam logic [c_ins_w-1:0] c_ins_nop     = 5'd0;
  localparam logic [c_ins_w-1:0] c_ins_trng    = 5'd18;
  localparam logic [c_ins_w-1:0] c_ins_aes_enc = 5'd19;
  localparam logic [c_ins_w-1:0] c_ins_aes_dec = 5'd20;
  localparam logic [c_ins_w-1:0] c_ins_padd    = 5'd22;
  localparam logic [c_ins_w-1:0] c_ins_psub    = 5'd23;
  localparam logic [c_ins_w-1:0] c_ins_pmul    = 5'd24;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_CLEAR  = 3'd3,
    S_FINISH = 3'd4
  } seq_state_t;

  // Only register-0 writes of a real instruction occupy the core.
  function automatic logic needs_wait(input logic [c_entry_w-1:0] entry);
    return !entry[c_entry_w-1] && (entry[c_ins_w-1:0] != c_ins_nop);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ins_sequencer_cmd_fifo.sv
`default_nettype none
// ============================================================================
// cmd_fifo
// Synchronous DEPTH x WIDTH command FIFO with occupancy count and flush.
// Revision: 1.0
// ============================================================================
module cmd_fifo
  import ins_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = c_entry_w
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_count == (c_aw + 1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ins_sequencer.sv
`default_nettype none
// ============================================================================
// ins_sequencer
// Drains queued host commands into the compute core, waiting for completion
// and clearing with a NOP after each instruction. Watchdog: SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module ins_sequencer
  import ins_sequencer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [35:0]            cmd_in,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   start,
  output logic [34:0]            command_in,
  output logic                   command_we0,
  output logic                   command_we1,
  input  logic                   done_ins_computation,
  output logic                   busy,
  output logic                   seq_done,
  output logic [7:0]             ins_count,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   error_timeout
);

  localparam int c_lim    = (GUARD > TIMEOUT) ? GUARD : TIMEOUT;
  localparam int c_wait_w = $clog2(c_lim + 2);

  seq_state_t           r_state;
  logic [c_cmd_w-1:0]   r_command;
  logic                 r_we0;
  logic                 r_we1;
  logic                 r_busy;
  logic                 r_seq_done;
  logic [7:0]           r_ins_count;
  logic                 r_need_wait;
  logic [c_wait_w-1:0]  r_wait_cnt;

  logic [c_entry_w-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_done_ok;
  logic                 w_timeout;
  logic                 w_abort;

  assign cmd_ready   = !w_full;
  assign w_push      = cmd_valid && !w_full;
  assign command_in  = r_command;
  assign command_we0 = r_we0;
  assign command_we1 = r_we1;
  assign busy        = r_busy;
  assign seq_done    = r_seq_done;
  assign ins_count   = r_ins_count;
  assign w_done_ok   = (r_state == S_WAIT) && done_ins_computation &&
                       (r_wait_cnt >= c_wait_w'(GUARD));

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_entry_w)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (w_timeout),
    .push  (w_push),
    .din   (cmd_in),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

`ifdef SEQ_TIMEOUT_EN
  logic r_error;
  logic r_abort;

  assign w_timeout     = (r_state == S_WAIT) && !w_done_ok &&
                         (r_wait_cnt == c_wait_w'(TIMEOUT - 1));
  assign w_abort       = r_abort;
  assign error_timeout = r_error;

  // Abort forces the post-timeout CLEAR to finish even if the host pushed meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
      r_abort <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
      r_abort <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_abort <= 1'b0;
    end
  end
`else
  assign w_timeout     = 1'b0;
  assign w_abort       = 1'b0;
  assign error_timeout = 1'b0;
`endif

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = start && !w_empty;
      S_ISSUE: w_pop = !r_need_wait && !w_empty;
      S_CLEAR: w_pop = !w_abort && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  // Writes are registered on the transition, so each write lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_command   <= '0;
      r_we0       <= 1'b0;
      r_we1       <= 1'b0;
      r_busy      <= 1'b0;
      r_seq_done  <= 1'b0;
      r_ins_count <= '0;
      r_need_wait <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_command  <= '0;
      r_we0      <= 1'b0;
      r_we1      <= 1'b0;
      r_seq_done <= 1'b0;
      if (w_pop) begin
        r_command   <= w_head[c_cmd_w-1:0];
        r_we1       <= w_head[c_entry_w-1];
        r_we0       <= !w_head[c_entry_w-1];
        r_need_wait <= needs_wait(w_head);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_pop) begin
              r_state <= S_ISSUE;
            end else begin
              r_state    <= S_FINISH;
              r_seq_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (r_need_wait) begin
            r_state     <= S_WAIT;
            r_ins_count <= r_ins_count + 8'd1;
            r_wait_cnt  <= '0;
          end else if (w_pop) begin
            r_state <= S_ISSUE;
          end else begin
            r_state    <= S_FINISH;
            r_seq_done <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_done_ok || w_timeout) begin
            r_state <= S_CLEAR;
            r_we0   <= 1'b1;
          end else if (!(&r_wait_cnt)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_CLEAR: begin
          if (w_pop) begin
            r_state <= S_ISSUE;
          end else begin
            r_state    <= S_FINISH;
            r_seq_done <= 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ins_sequencer.md
INS_SEQUENCER -- requirements
Module: ins_sequencer

Interface
REQ-001 SHALL have parameters: DEPTH, default 16, command FIFO entries (power of 2, 4..256); GUARD, default 2, cycles done_ins_computation is ignored after issue; TIMEOUT, default 65535, watchdog limit in cycles.
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: cmd_in  in  36  host entry; [34:0] core command, [35] target (0=command_reg0, 1=command_reg1).
REQ-005 SHALL have ports: cmd_valid  in  1 / cmd_ready  out  1  host push handshake.
REQ-006 SHALL have ports: start  in  1  begin executing queued entries.
REQ-007 SHALL have ports: command_in  out  35 / command_we0  out  1 / command_we1  out  1  drive the compute core command registers.
REQ-008 SHALL have ports: done_ins_computation  in  1  core completion level.
REQ-009 SHALL have ports: busy  out  1; seq_done  out  1 pulse; ins_count  out  8 executed we0 instructions; fifo_count  out  log2(DEPTH)+1; error_timeout  out  1.

Function
REQ-010 SHALL push when cmd_valid && cmd_ready; cmd_ready = !full, independent of same-cycle pop.
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, CLEAR, FINISH.
REQ-012 IDLE: on start with fifo_count>0 -> ISSUE; start with empty FIFO -> FINISH; start ignored outside IDLE.
REQ-013 ISSUE: pop head; drive command_in=head[34:0] for one cycle with command_we1=1 if head[35] else command_we0=1; never both.
REQ-014 After ISSUE: we1 entry or we0 entry with INS (bits [4:0]) = 0 -> ISSUE if FIFO non-empty, else FINISH; other we0 entry -> WAIT and increment ins_count (wraps 255->0).
REQ-015 WAIT: ignore done_ins_computation for the first GUARD cycles; thereafter done high -> CLEAR.
REQ-016 CLEAR: one cycle, command_in=0, command_we0=1 (NOP, returns all units to reset); then ISSUE if FIFO non-empty else FINISH.
REQ-017 FINISH: seq_done=1 for exactly one cycle, then IDLE.
REQ-018 Entries pushed during execution SHALL be executed in the same run if present when CLEAR/ISSUE evaluates emptiness.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 command_we0/command_we1 SHALL be 0 and command_in SHALL be 0 in every cycle without a write.
REQ-021 Push into full FIFO SHALL be refused (no overwrite); pop never occurs when empty.

Reset
REQ-022 rst SHALL, in the cycle after assertion, force IDLE, flush FIFO (fifo_count=0, cmd_ready=1), clear ins_count, error_timeout, seq_done, busy, command_in, command_we0, command_we1.
REQ-023 rst mid-operation SHALL abandon the in-flight instruction without issuing CLEAR.

Configuration
REQ-024 With SEQ_TIMEOUT_EN defined: WAIT counts cycles; reaching TIMEOUT without done SHALL set sticky error_timeout, flush FIFO, go CLEAR then FINISH; cleared only by rst.
REQ-025 Without SEQ_TIMEOUT_EN: no counter, WAIT unbounded, error_timeout tied 0.

Structure
REQ-026 Shared package SHALL hold FSM state encoding, INS opcode constants (NOP=0, TRNG=18, AES_ENC=19, AES_DEC=20, PADD=22, PSUB=23, PMUL=24), command field widths (5/10/10/10).
REQ-027 FIFO SHALL be sub-module cmd_fifo (synchronous, DEPTH x 36, count output).

Verification
REQ-028 Push {0, PMUL cmd}, start, done rises 50 cycles after issue -> one we0 with command, CLEAR NOP one cycle after done seen, seq_done pulse, ins_count=1.
REQ-029 Push we1 entry then we0 PADD entry, start -> command_we1 cycle then command_we0 next cycle with no wait; one WAIT.
REQ-030 Hold done_ins_computation=1 constantly, issue TRNG -> CLEAR no earlier than GUARD+1 cycles after issue.
REQ-031 Push 17 entries with DEPTH=16 -> cmd_ready=0 after 16th, 17th refused, fifo_count=16.
REQ-032 Assert rst during WAIT with 3 queued -> next cycle all outputs 0, fifo_count=0, no CLEAR issued.
REQ-033 SEQ_TIMEOUT_EN, TIMEOUT=100, done never rises -> error_timeout=1 at cycle 100 of WAIT, NOP CLEAR, seq_done, FIFO empty.
